mac_scheduler: RTL and testbench
================================

# mac_scheduler

Round-robin burst scheduler sharing one square-and-accumulate datapath among `NREQ` requesters. Each requester streams 8-bit samples with a valid/ready handshake and marks its final sample with `req_last`. The scheduler locks the datapath to one requester for a whole burst and emits the burst's sum of squares tagged with the requester id. It sits between the sample producers and the downstream result consumer, and replaces the single-stream accumulator where multiple sources share it.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `DW`, 8: sample width.
- `AW`, 20: accumulator/result width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `req_valid` in NREQ: per-requester sample valid.
- `req_data` in NREQ*DW: flattened samples; requester i occupies bits [i*DW +: DW].
- `req_last` in NREQ: marks the final sample of a burst; qualified by valid&ready.
- `req_ready` out NREQ: one-hot or zero grant; combinational.
- `out_valid` out 1: one-cycle pulse, burst result available.
- `out_id` out $clog2(NREQ): requester that owned the burst.
- `out_f` out AW: burst sum of squares.
- `overflow` out 1: burst overflowed AW bits (see Configuration).

## Operation
- FSM states:
  - IDLE: the arbiter picks the first asserted `req_valid` at or after `rr_ptr`, scanning upward and wrapping. `req_ready` is high for that requester only. A handshake with `req_last=0` moves the FSM to BURST with owner = granted id. A handshake with `req_last=1` is a one-sample burst and the FSM stays in IDLE.
  - BURST: `req_ready[owner]` = 1 and all others are 0, regardless of their valid. Owner gaps (valid low) are allowed and the FSM holds state. A handshake with `req_last=1` returns the FSM to IDLE.
- Handshake is `req_valid[i] & req_ready[i]`. At most one handshake occurs per cycle.
- `rr_ptr` updates to (owner+1) mod NREQ on the edge capturing a last sample.
- Stage 1 register captures {sample, id, last} on the handshake edge. Stage 1 has its own valid bit.
- Stage 2, on the next edge: `acc <= acc + sample*sample`. The product is 2*DW bits, zero-extended to AW, and the sum is truncated modulo 2^AW.
  - If last: `out_f <= acc + sample*sample`, `out_id <= id`, `out_valid <= 1`, and `acc <= 0`.
- `out_valid` is 1 for exactly one cycle. `out_f`/`out_id` hold until the next result.
- Samples with `req_valid=0` never reach stage 1. The `req_data` value during a non-handshake cycle has no effect.
- Reset (asynchronous, any time, mid-burst included) drives:
  - FSM to IDLE, `rr_ptr` to 0, `acc` to 0, stage-1 valid to 0.
  - `out_valid` to 0, `out_id` to 0, `out_f` to 0, `overflow` to 0.
  - `req_ready` follows the IDLE arbitration combinationally once reset deasserts.
- A partial burst is discarded by reset.

## Timing
- Arbitration has zero latency: `req_ready` is valid in the same cycle as `req_valid`.
- If the last-sample handshake is at edge E, `out_valid` is high in the cycle after edge E+1.
- Back-to-back bursts with no bubble: after the last handshake at E, a new grant is available in the cycle following E. Its first sample adds to `acc`, which was cleared at E+1.
- Throughput: one sample per cycle sustained, across requester switches.
- A consumer has no backpressure on `out_*`. Results may pulse in consecutive cycles (one-sample bursts).

## Configuration
- `MAC_SCHED_OVERFLOW_EN` defined: a sticky overflow bit is set when any accumulate in the burst carries out of AW bits.
  - It is cleared together with `acc` at burst end.
  - `overflow` is registered alongside `out_f` and is valid when `out_valid` is 1.
  - `out_f` still wraps.
- Macro undefined: no carry logic, and `overflow` is tied to 0.

## Structure
- Package `mac_sched_pkg` holds:
  - `sched_state_t` enum {IDLE, BURST}.
  - typedefs `sample_t` (DW bits) and `acc_t` (AW bits).
  - default constants `MAC_NREQ=4`, `MAC_DW=8`, `MAC_AW=20`.
- Sub-module `rr_arbiter` is combinational: it takes (`req_valid`, `rr_ptr`) and returns a one-hot grant plus the encoded id. `mac_scheduler` instantiates it and applies the BURST lock around it.

## Test plan
- Single burst: requester 0 sends 21 then 36 (last). Required: `out_valid` pulses once, `out_id=0`, `out_f=1737`. Before that, `out_valid=0` and `out_f=0` after reset.
- Burst lock: requester 1 sends 3 then a 2-cycle valid gap then 4 (last), while requester 2 holds valid high throughout. Required: `req_ready[2]=0` until requester 1's last handshake. Result has `out_id=1`, `out_f=25`. Requester 2 is granted in the next cycle.
- Round-robin: requesters 0 and 2 both valid with one-sample bursts (a=1 and a=2) continuously, `rr_ptr=0`. Required: grant order is 0,2,0,2. `out_f` alternates 1,4 with `out_valid` high every cycle.
- Overflow (macro defined): requester 3 sends 17 samples of 255, the last one flagged last. Required: `out_f=56849`, `overflow=1`. The next burst of a single 1 gives `out_f=1`, `overflow=0`.
- Reset mid-burst: requester 0 sends 200 and 200, then `reset` is driven low asynchronously between edges. Required: all outputs are 0 immediately. After release, requester 0 sends 10 (last) and the required result is `out_f=100` with no residue.

Source files
------------

// File: rtl/mac_sched_pkg.sv
// Shared types, default sizes and a wrap-around index helper for mac_scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_sched_pkg;

    localparam int MAC_NREQ = 4;
    localparam int MAC_DW   = 8;
    localparam int MAC_AW   = 20;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } sched_state_t;

    typedef logic [MAC_DW-1:0] sample_t;
    typedef logic [MAC_AW-1:0] acc_t;

    // (base + ofs) mod n, for base < n and ofs < n; avoids a divider
    function automatic int rr_wrap(input int base, input int ofs, input int n);
        int s;
        s = base + ofs;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/mac_scheduler_rr_arbiter.sv
// Round-robin picker: first asserted req_valid at or after rr_ptr, wrapping.
// Latency: combinational, zero cycles.
// Backpressure: none; grant is simply zero when nothing is valid.
// Ports: req_valid/rr_ptr in; gnt (one-hot or zero), gnt_id (encoded), gnt_any out.
module rr_arbiter
    import mac_sched_pkg::*;
#(
    parameter int NREQ = MAC_NREQ,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_id,
    output logic            gnt_any
);

    logic [IW-1:0] idx;

    // Scan from the farthest offset down so the nearest valid requester wins.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = IW'(rr_wrap(int'(rr_ptr), k, NREQ));
            if (req_valid[idx]) begin
                gnt_id  = idx;
                gnt_any = 1'b1;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_any) gnt[gnt_id] = 1'b1;
    end

endmodule

// File: rtl/mac_scheduler.sv
// Round-robin burst scheduler feeding one shared square-and-accumulate datapath.
// Latency: last-sample handshake at edge E -> out_valid pulse after edge E+1.
// Backpressure: req_ready holds off non-owners; out_* has none (one-cycle pulse).
// Ports: clk, reset (async active-low); req_valid/req_data/req_last in, req_ready out;
//        out_valid/out_id/out_f/overflow out.
// Option: MAC_SCHED_OVERFLOW_EN adds a sticky per-burst carry flag on overflow.
module mac_scheduler
    import mac_sched_pkg::*;
#(
    parameter int NREQ = MAC_NREQ,
    parameter int DW   = MAC_DW,
    parameter int AW   = MAC_AW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*DW-1:0]      req_data,
    input  logic [NREQ-1:0]         req_last,
    output logic [NREQ-1:0]         req_ready,
    output logic                    out_valid,
    output logic [$clog2(NREQ)-1:0] out_id,
    output logic [AW-1:0]           out_f,
    output logic                    overflow
);

    localparam int IW = $clog2(NREQ);

    sched_state_t    state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_id;
    logic            arb_any;

    logic [NREQ-1:0] ready_int;
    logic            hs_any;
    logic            hs_last;
    logic [IW-1:0]   hs_id;
    logic [DW-1:0]   hs_data;

    logic            s1_vld_q, s1_vld_d;
    logic [DW-1:0]   s1_dat_q, s1_dat_d;
    logic [IW-1:0]   s1_id_q, s1_id_d;
    logic            s1_last_q, s1_last_d;

    logic [2*DW-1:0] sq;
    logic [AW-1:0]   sum_lo;
    logic [AW-1:0]   acc_q, acc_d;
    logic            out_valid_q, out_valid_d;
    logic [IW-1:0]   out_id_q, out_id_d;
    logic [AW-1:0]   out_f_q, out_f_d;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .gnt       (arb_gnt),
        .gnt_id    (arb_id),
        .gnt_any   (arb_any)
    );

    // During a burst the owner alone is ready, even across its own valid gaps.
    always_comb begin
        ready_int = '0;
        if (state_q == BURST) ready_int[owner_q] = 1'b1;
        else                  ready_int = arb_gnt;
    end

    // Held at zero while reset is asserted so no handshake can be seen then.
    assign req_ready = reset ? ready_int : '0;
    assign hs_any    = |(req_valid & req_ready);
    assign hs_id     = (state_q == BURST) ? owner_q : arb_id;
    assign hs_last   = req_last[hs_id];
    assign hs_data   = req_data[int'(hs_id)*DW +: DW];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (hs_any) begin
            if (hs_last) begin
                state_d  = IDLE;
                rr_ptr_d = IW'(rr_wrap(int'(hs_id), 1, NREQ));
            end else begin
                state_d = BURST;
                owner_d = hs_id;
            end
        end
    end

    always_comb begin
        s1_vld_d  = hs_any;
        s1_dat_d  = hs_any ? hs_data : s1_dat_q;
        s1_id_d   = hs_any ? hs_id   : s1_id_q;
        s1_last_d = hs_any ? hs_last : s1_last_q;
    end

    assign sq = s1_dat_q * s1_dat_q;

    always_comb begin
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_f_d     = out_f_q;
        out_id_d    = out_id_q;
        if (s1_vld_q) begin
            if (s1_last_q) begin
                out_f_d     = sum_lo;
                out_id_d    = s1_id_q;
                out_valid_d = 1'b1;
                acc_d       = '0;
            end else begin
                acc_d = sum_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            s1_vld_q    <= 1'b0;
            s1_dat_q    <= '0;
            s1_id_q     <= '0;
            s1_last_q   <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_f_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            s1_vld_q    <= s1_vld_d;
            s1_dat_q    <= s1_dat_d;
            s1_id_q     <= s1_id_d;
            s1_last_q   <= s1_last_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_f_q     <= out_f_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_f     = out_f_q;

`ifdef MAC_SCHED_OVERFLOW_EN
    logic carry;
    logic ovf_sticky_q, ovf_sticky_d;
    logic overflow_q, overflow_d;

    assign {carry, sum_lo} = {1'b0, acc_q} + (AW+1)'(sq);

    // Sticky across the burst; folded into the result and cleared with acc.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        overflow_d   = overflow_q;
        if (s1_vld_q) begin
            if (s1_last_q) begin
                overflow_d   = ovf_sticky_q | carry;
                ovf_sticky_d = 1'b0;
            end else begin
                ovf_sticky_d = ovf_sticky_q | carry;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_sticky_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            overflow_q   <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign sum_lo   = acc_q + AW'(sq);
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mac_scheduler.sv
// Self-checking bench for mac_scheduler: directed scenarios plus randomized streams.
// Reference model tracks grants and per-burst sums of squares with plain arithmetic.
// Outputs sampled 1 time unit after the rising edge; inputs driven then too.
module tb_mac_scheduler;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 20;
    localparam int IW   = 2;
    localparam longint MODV = 64'd1 << AW;
`ifdef MAC_SCHED_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      req_ready;
    logic                 out_valid;
    logic [IW-1:0]        out_id;
    logic [AW-1:0]        out_f;
    logic                 overflow;

    mac_scheduler #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_f     (out_f),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          vld;
        logic          last;
        logic [DW-1:0] dat;
    } slot_t;

    slot_t  sq [NREQ][$];
    int     due_q[$];
    int     rid_q[$];
    longint rf_q[$];
    bit     rovf_q[$];
    int     log_id[$];
    longint log_f[$];
    bit     log_ovf[$];

    int     owner, rr, edge_n, checks, failures;
    longint bsum, held_f;
    int     held_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_smp(input int r, input int d, input bit last);
        slot_t s;
        s.vld = 1'b1; s.last = last; s.dat = DW'(d);
        sq[r].push_back(s);
    endtask

    task automatic push_gap(input int r, input int n);
        slot_t s;
        s.vld = 1'b0; s.last = 1'b0; s.dat = '0;
        repeat (n) sq[r].push_back(s);
    endtask

    task automatic clear_log();
        log_id.delete(); log_f.delete(); log_ovf.delete();
    endtask

    function automatic logic [NREQ-1:0] exp_ready();
        logic [NREQ-1:0] v;
        v = '0;
        if (owner >= 0) v[owner] = 1'b1;
        else begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (rr + k) % NREQ;
                if (req_valid[i]) begin
                    v[i] = 1'b1;
                    break;
                end
            end
        end
        return v;
    endfunction

    function automatic bit busy();
        bit b;
        b = (due_q.size() > 0) || (owner >= 0);
        for (int i = 0; i < NREQ; i++) if (sq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic check_outputs();
        bit ev, eo;
        ev = 1'b0; eo = 1'b0;
        while (due_q.size() > 0 && due_q[0] < edge_n) begin
            void'(due_q.pop_front()); void'(rid_q.pop_front());
            void'(rf_q.pop_front());  void'(rovf_q.pop_front());
        end
        if (due_q.size() > 0 && due_q[0] == edge_n) begin
            ev = 1'b1;
            void'(due_q.pop_front());
            held_f  = rf_q.pop_front();
            held_id = rid_q.pop_front();
            eo      = rovf_q.pop_front();
        end
        if (out_valid === 1'b1) begin
            log_id.push_back(int'(out_id));
            log_f.push_back(longint'(out_f));
            log_ovf.push_back(overflow);
        end
        chk("out_valid", out_valid, ev);
        chk("out_f", out_f, held_f);
        chk("out_id", out_id, held_id);
        if (ev) chk("overflow", overflow, OVF_EN ? eo : 1'b0);
    endtask

    // One clock: drive streams, check grant, advance the model, check outputs.
    task automatic cycle();
        logic [NREQ-1:0] er, hs;
        for (int i = 0; i < NREQ; i++) begin
            if (sq[i].size() > 0 && sq[i][0].vld) begin
                req_valid[i] = 1'b1;
                req_last[i]  = sq[i][0].last;
                req_data[i*DW +: DW] = sq[i][0].dat;
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'($urandom);
                req_data[i*DW +: DW] = DW'($urandom);
            end
        end
        #1;
        er = exp_ready();
        chk("req_ready", req_ready, er);
        hs = er & req_valid;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i]) begin
                bsum += longint'(sq[i][0].dat) * longint'(sq[i][0].dat);
                if (sq[i][0].last) begin
                    due_q.push_back(edge_n + 2);
                    rid_q.push_back(i);
                    rf_q.push_back(bsum % MODV);
                    rovf_q.push_back(bsum >= MODV);
                    bsum  = 0;
                    owner = -1;
                    rr    = (i + 1) % NREQ;
                end else begin
                    owner = i;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (sq[i].size() > 0) begin
                if (!sq[i][0].vld || hs[i]) void'(sq[i].pop_front());
            end
        end
        @(posedge clk);
        edge_n++;
        #1;
        check_outputs();
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        #2;
        req_valid = '1;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_f", out_f, '0);
        chk("rst_out_id", out_id, '0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        owner = -1; rr = 0; bsum = 0; held_f = 0; held_id = 0;
        due_q.delete(); rid_q.delete(); rf_q.delete(); rovf_q.delete();
        for (int i = 0; i < NREQ; i++) sq[i].delete();
        @(posedge clk);
        @(posedge clk);
        #3;
        req_valid = '0;
        reset = 1'b1;
        @(posedge clk);
        edge_n += 3;
        #1;
        chk("post_rst_out_valid", out_valid, 1'b0);
        chk("post_rst_out_f", out_f, '0);
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            cycle();
            n++;
        end
        chk("idle_timeout", busy(), 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; owner = -1; rr = 0; bsum = 0;
        edge_n = 0; held_f = 0; held_id = 0;
        reset = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        do_reset();

        // single burst: 21^2 + 36^2 = 1737
        clear_log();
        push_smp(0, 21, 1'b0); push_smp(0, 36, 1'b1);
        run_until_idle(50);
        chk("single_cnt", log_f.size(), 1);
        if (log_f.size() >= 1) begin
            chk("single_f", log_f[0], 1737);
            chk("single_id", log_id[0], 0);
        end

        // burst lock: owner 1 with a 2-cycle gap, requester 2 waiting throughout
        do_reset();
        clear_log();
        push_smp(1, 3, 1'b0); push_gap(1, 2); push_smp(1, 4, 1'b1);
        push_smp(2, 9, 1'b1);
        run_until_idle(50);
        chk("lock_cnt", log_f.size(), 2);
        if (log_f.size() >= 2) begin
            chk("lock_id0", log_id[0], 1);
            chk("lock_f0", log_f[0], 25);
            chk("lock_id1", log_id[1], 2);
            chk("lock_f1", log_f[1], 81);
        end

        // round-robin between requesters 0 and 2 with one-sample bursts
        do_reset();
        clear_log();
        repeat (4) begin
            push_smp(0, 1, 1'b1);
            push_smp(2, 2, 1'b1);
        end
        run_until_idle(50);
        chk("rr_cnt", log_f.size(), 8);
        for (int k = 0; k < log_f.size() && k < 8; k++) begin
            chk("rr_id", log_id[k], (k % 2 == 0) ? 0 : 2);
            chk("rr_f", log_f[k], (k % 2 == 0) ? 1 : 4);
        end

        // wrap: 17 * 65025 = 1105425 -> 56849 mod 2^20
        clear_log();
        repeat (16) push_smp(3, 255, 1'b0);
        push_smp(3, 255, 1'b1);
        push_smp(3, 1, 1'b1);
        run_until_idle(80);
        chk("ovf_cnt", log_f.size(), 2);
        if (log_f.size() >= 2) begin
            chk("ovf_f0", log_f[0], 56849);
            chk("ovf_flag0", log_ovf[0], OVF_EN);
            chk("ovf_id0", log_id[0], 3);
            chk("ovf_f1", log_f[1], 1);
            chk("ovf_flag1", log_ovf[1], 1'b0);
        end

        // reset in the middle of a burst discards the partial sum
        push_smp(0, 200, 1'b0); push_smp(0, 200, 1'b0);
        cycle();
        cycle();
        do_reset();
        clear_log();
        push_smp(0, 10, 1'b1);
        run_until_idle(50);
        chk("mid_rst_cnt", log_f.size(), 1);
        if (log_f.size() >= 1) begin
            chk("mid_rst_f", log_f[0], 100);
            chk("mid_rst_id", log_id[0], 0);
        end

        // randomized streams on all requesters
        for (int r = 0; r < NREQ; r++) begin
            for (int b = 0; b < 8; b++) begin
                int len;
                len = $urandom_range(1, 6);
                for (int s = 0; s < len; s++) begin
                    if ($urandom_range(0, 3) == 0) push_gap(r, $urandom_range(1, 2));
                    push_smp(r, $urandom_range(0, 255), s == len - 1);
                end
                if ($urandom_range(0, 2) == 0) push_gap(r, $urandom_range(1, 4));
            end
        end
        run_until_idle(2000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
